sram_responder: RTL and testbench

- Clocked model of the external 16-bit asynchronous SRAM, sitting on the far side of the MEM stage's SRAM pins (SRAM_ADDR, SRAM_DQ, SRAM_WE_N plus chip/output/byte enables).
- Responds to controller reads and writes with programmable latency and byte-lane masking.
- Flags controller timing violations, so the MEM-stage SRAM controller can be verified in closed loop.
- Integration only: the block is a behavioural stand-in for the device and is not part of the CPU pipeline.

---
 rtl/sram_responder_if.sv | 25 ++
 rtl/sram_responder.sv | 109 ++++++++++
 tb/tb_sram_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// Pin bundle between the MEM-stage SRAM controller and the SRAM behavioural model.
// The 16-bit data bus stays a plain inout port on the responder.
interface sram_responder_if #(
    parameter int ADDR_WIDTH = 18
);
    logic [ADDR_WIDTH-1:0] SRAM_ADDR;
    logic                  SRAM_WE_N;
    logic                  SRAM_OE_N;
    logic                  SRAM_CE_N;
    logic                  SRAM_UB_N;
    logic                  SRAM_LB_N;
    logic                  rd_valid;
    logic                  wr_commit;
    logic                  timing_err;

    modport master (
        output SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N,
        input  rd_valid, wr_commit, timing_err
    );

    modport slave (
        input  SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N,
        output rd_valid, wr_commit, timing_err
    );
endinterface

// File: rtl/sram_responder.sv
// Clocked stand-in for a 16-bit asynchronous SRAM: latency-checked reads and
// byte-masked writes, with a sticky flag for controller timing violations.
module sram_responder #(
    parameter int ADDR_WIDTH     = 18,
    parameter int MEM_DEPTH_LOG2 = 16,
    parameter int READ_LATENCY   = 2,
    parameter int WRITE_LATENCY  = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_responder_if.slave     bus,
    inout  wire  [15:0]         SRAM_DQ
);
    localparam int CNT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = ADDR_WIDTH + 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_e;

    function automatic state_e decode(input logic we_n, input logic ce_n, input logic oe_n);
        if (ce_n)       return ST_IDLE;
        else if (!we_n) return ST_WRITE;
        else if (!oe_n) return ST_READ;
        else            return ST_IDLE;
    endfunction

    logic [SW-1:0]             cur_s;
    logic [SW-1:0]             prev_s_q, prev_s_d;
    logic [CW-1:0]             stable_cnt_q, stable_cnt_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      wr_commit_q, wr_commit_d;
    logic                      timing_err_q, timing_err_d;
    logic [15:0]               rd_data_q, rd_data_d;
    logic                      s_changed;
    logic                      drive_en;
    logic [MEM_DEPTH_LOG2-1:0] mem_idx;
    state_e                    state, prev_state;

    logic [15:0] mem [2**MEM_DEPTH_LOG2];

    assign cur_s      = {bus.SRAM_ADDR, bus.SRAM_WE_N, bus.SRAM_CE_N, bus.SRAM_OE_N};
    assign s_changed  = (cur_s != prev_s_q);
    assign state      = decode(bus.SRAM_WE_N, bus.SRAM_CE_N, bus.SRAM_OE_N);
    assign prev_state = decode(prev_s_q[2], prev_s_q[1], prev_s_q[0]);
    assign mem_idx    = bus.SRAM_ADDR[MEM_DEPTH_LOG2-1:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        prev_s_d     = cur_s;
        stable_cnt_d = stable_cnt_q;
        rd_data_d    = mem[mem_idx];
        timing_err_d = timing_err_q;

        if (s_changed)
            stable_cnt_d = CW'(1);
        else if (stable_cnt_q != CW'(CNT_MAX))
            stable_cnt_d = stable_cnt_q + 1'b1;

        rd_valid_d = (state == ST_READ) && (stable_cnt_d >= CW'(READ_LATENCY));

        // Commit only on the edge the count first reaches the latency, so a long WE_N pulse writes once.
        wr_commit_d = (state == ST_WRITE) && (stable_cnt_d == CW'(WRITE_LATENCY)) &&
                      (s_changed || stable_cnt_q < CW'(WRITE_LATENCY));

        if (prev_state == ST_WRITE && s_changed && stable_cnt_q < CW'(WRITE_LATENCY))
            timing_err_d = 1'b1;
        if (state != ST_IDLE && bus.SRAM_UB_N && bus.SRAM_LB_N)
            timing_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_s_q     <= '1;
            stable_cnt_q <= '0;
            rd_valid_q   <= 1'b0;
            wr_commit_q  <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            prev_s_q     <= prev_s_d;
            stable_cnt_q <= stable_cnt_d;
            rd_valid_q   <= rd_valid_d;
            wr_commit_q  <= wr_commit_d;
            timing_err_q <= timing_err_d;
        end
    end

    // NOTE: the storage array and read register carry no reset; contents must survive rst like a real SRAM.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
        if (wr_commit_d && !rst) begin
            if (!bus.SRAM_UB_N) mem[mem_idx][15:8] <= SRAM_DQ[15:8];
            if (!bus.SRAM_LB_N) mem[mem_idx][7:0]  <= SRAM_DQ[7:0];
        end
    end

    // Combinational so the bus releases in the same cycle the controller turns around.
    assign drive_en = rd_valid_q & bus.SRAM_WE_N & ~bus.SRAM_OE_N & ~bus.SRAM_CE_N;

    assign SRAM_DQ[15:8] = (drive_en && !bus.SRAM_UB_N) ? rd_data_q[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (drive_en && !bus.SRAM_LB_N) ? rd_data_q[7:0]  : 8'hzz;

    assign bus.rd_valid   = rd_valid_q;
    assign bus.wr_commit  = wr_commit_q;
    assign bus.timing_err = timing_err_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed closed-loop bench for sram_responder; read data is checked by a
// scoreboard monitor that pops an expected-value queue on each rd_valid rise.
module tb_sram_responder;
    localparam int ADDR_WIDTH = 18;

    logic        clk;
    logic        rst;
    logic [15:0] tb_dq;
    logic        tb_drv;
    wire  [15:0] sram_dq;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic        rd_valid_prev;

    sram_responder_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    sram_responder #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .MEM_DEPTH_LOG2(16),
        .READ_LATENCY  (2),
        .WRITE_LATENCY (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .SRAM_DQ(sram_dq)
    );

    // A released bus reads back as all ones.
    pullup (sram_dq);
    assign sram_dq = tb_drv ? tb_dq : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one comparison per rising edge of rd_valid.
    initial rd_valid_prev = 1'b0;
    always @(posedge clk) begin
        #2;
        if (bus.rd_valid && !rd_valid_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL read_unexpected actual=%h expected=none", sram_dq);
            end else begin
                check("read_data", {16'h0, sram_dq}, {16'h0, exp_q.pop_front()});
            end
        end
        rd_valid_prev = bus.rd_valid;
    end

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.SRAM_CE_N = 1'b1;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = 1'b0;
        bus.SRAM_LB_N = 1'b0;
        tb_drv        = 1'b0;
    endtask

    // Hold a write for 'edges' clock edges; commit is expected on edge 2 only.
    task automatic do_write(input logic [17:0] addr, input logic [15:0] data,
                            input logic ub_n, input logic lb_n, input int edges);
        @(negedge clk);
        bus.SRAM_ADDR = addr;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = ub_n;
        bus.SRAM_LB_N = lb_n;
        tb_dq         = data;
        tb_drv        = 1'b1;
        for (int i = 1; i <= edges; i++) begin
            post_edge();
            check($sformatf("wr_commit_edge%0d", i), {31'h0, bus.wr_commit}, {31'h0, (i == 2)});
        end
        go_idle();
    endtask

    task automatic do_read(input logic [17:0] addr, input logic ub_n, input logic lb_n,
                           input logic [15:0] exp);
        @(negedge clk);
        bus.SRAM_ADDR = addr;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_UB_N = ub_n;
        bus.SRAM_LB_N = lb_n;
        exp_q.push_back(exp);
        post_edge();
        check("read_edge1_valid", {31'h0, bus.rd_valid}, 32'h0);
        check("read_edge1_bus_z", {16'h0, sram_dq}, 32'h0000_ffff);
        post_edge();
        check("read_edge2_valid", {31'h0, bus.rd_valid}, 32'h1);
        post_edge();
        go_idle();
        #1;
        check("read_release_z", {16'h0, sram_dq}, 32'h0000_ffff);
    endtask

    initial begin
        rst           = 1'b1;
        tb_drv        = 1'b0;
        tb_dq         = 16'h0000;
        bus.SRAM_ADDR = '0;
        bus.SRAM_CE_N = 1'b1;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = 1'b0;
        bus.SRAM_LB_N = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
        check("reset_wr_commit", {31'h0, bus.wr_commit}, 32'h0);
        check("reset_timing_err", {31'h0, bus.timing_err}, 32'h0);
        check("reset_bus_z", {16'h0, sram_dq}, 32'h0000_ffff);
        rst = 1'b0;

        // Full-word write held three edges: exactly one commit.
        do_write(18'd5, 16'h1234, 1'b0, 1'b0, 3);
        do_read(18'd5, 1'b0, 1'b0, 16'h1234);

        // Upper lane only.
        do_write(18'd5, 16'hABCD, 1'b0, 1'b1, 2);
        do_read(18'd5, 1'b0, 1'b0, 16'hAB34);
        check("no_err_after_clean_ops", {31'h0, bus.timing_err}, 32'h0);

        // Reference value at addr 7, then an aborted write there.
        do_write(18'd7, 16'h0777, 1'b0, 1'b0, 2);
        @(negedge clk);
        bus.SRAM_ADDR = 18'd7;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        tb_dq         = 16'h7777;
        tb_drv        = 1'b1;
        post_edge();
        check("abort_edge1_err", {31'h0, bus.timing_err}, 32'h0);
        @(negedge clk);
        bus.SRAM_ADDR = 18'd8;
        post_edge();
        check("abort_no_commit", {31'h0, bus.wr_commit}, 32'h0);
        check("abort_err_set", {31'h0, bus.timing_err}, 32'h1);
        go_idle();
        repeat (3) post_edge();
        check("abort_err_sticky", {31'h0, bus.timing_err}, 32'h1);

        // WE_N and OE_N low together: write wins, responder stays off the bus.
        @(negedge clk);
        bus.SRAM_ADDR = 18'd9;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b0;
        tb_dq         = 16'h5A5A;
        tb_drv        = 1'b1;
        post_edge();
        check("we_oe_edge1_valid", {31'h0, bus.rd_valid}, 32'h0);
        post_edge();
        check("we_oe_commit", {31'h0, bus.wr_commit}, 32'h1);
        check("we_oe_valid", {31'h0, bus.rd_valid}, 32'h0);
        check("we_oe_bus", {16'h0, sram_dq}, 32'h0000_5a5a);
        go_idle();
        do_read(18'd9, 1'b0, 1'b0, 16'h5A5A);
        do_read(18'd7, 1'b0, 1'b0, 16'h0777);

        // Reset asserted mid-read with data on the bus.
        @(negedge clk);
        bus.SRAM_ADDR = 18'd5;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b0;
        exp_q.push_back(16'hAB34);
        repeat (3) post_edge();
        check("pre_rst_valid", {31'h0, bus.rd_valid}, 32'h1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", {31'h0, bus.rd_valid}, 32'h0);
        check("rst_async_bus_z", {16'h0, sram_dq}, 32'h0000_ffff);
        check("rst_async_err", {31'h0, bus.timing_err}, 32'h0);
        go_idle();
        @(negedge clk);
        rst = 1'b0;
        do_read(18'd5, 1'b0, 1'b0, 16'hAB34);

        // Address aliasing above MEM_DEPTH_LOG2.
        do_read(18'h10005, 1'b0, 1'b0, 16'hAB34);

        // Lower lane released by the responder reads back pulled high.
        do_read(18'd5, 1'b0, 1'b1, 16'hABFF);
        check("single_lane_no_err", {31'h0, bus.timing_err}, 32'h0);

        // Both lanes disabled during an access is a violation.
        do_read(18'd5, 1'b1, 1'b1, 16'hFFFF);
        check("both_lanes_off_err", {31'h0, bus.timing_err}, 32'h1);

        repeat (3) post_edge();
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
